// File: rtl/cacheline_adaptor.sv
// Bridges a wide cacheline request port to a narrow burst-mode memory port.
// Fills are assembled beat-by-beat and writebacks are serialized; beat 0 is the low word.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   resp_i
);

  localparam int BEATS      = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W      = $clog2(BEATS);
  localparam int LINE_BYTES = LINE_WIDTH / 8;

  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        // Writeback has priority; a concurrent read stays asserted and is taken next IDLE.
        if (write_i) begin
          state_d = S_WR;
          addr_d  = address_i & LINE_MASK;
          line_d  = line_i;
          cnt_d   = '0;
        end else if (read_i) begin
          state_d = S_RD;
          addr_d  = address_i & LINE_MASK;
          cnt_d   = '0;
        end
      end
      S_RD: begin
        if (resp_i) begin
          line_d[cnt_q*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_WR: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  // Outputs decode registered state only, so there is no input-to-output path.
  assign read_o    = (state_q == S_RD);
  assign write_o   = (state_q == S_WR);
  assign resp_o    = (state_q == S_DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = line_q[cnt_q*BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a transaction-level model compared every cycle,
// plus literal expectations for the named scenarios.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i, write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o, write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int checks   = 0;
  int failures = 0;
  int resp_cnt = 0;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: what the memory side must look like, from request/beat events.
  logic        m_rd, m_wr, m_done;
  int          m_beats;
  logic [63:0] m_words [4];
  logic [31:0] m_addr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rd <= 0; m_wr <= 0; m_done <= 0; m_beats <= 0; m_addr <= '0;
      for (int k = 0; k < 4; k++) m_words[k] <= '0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (!m_rd && !m_wr) begin
      if (write_i) begin
        m_wr <= 1; m_beats <= 0; m_addr <= {address_i[31:5], 5'b0};
        for (int k = 0; k < 4; k++) m_words[k] <= line_i[k*64 +: 64];
      end else if (read_i) begin
        m_rd <= 1; m_beats <= 0; m_addr <= {address_i[31:5], 5'b0};
      end
    end else if (resp_i) begin
      if (m_rd) m_words[m_beats] <= burst_i;
      if (m_beats == 3) begin
        m_rd <= 0; m_wr <= 0; m_done <= 1; m_beats <= 0;
      end else begin
        m_beats <= m_beats + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_read_o", 256'(read_o), 256'(m_rd));
    chk("model_write_o", 256'(write_o), 256'(m_wr));
    chk("model_resp_o", 256'(resp_o), 256'(m_done));
    chk("model_address_o", 256'(address_o), 256'(m_addr));
    chk("model_line_o", line_o, {m_words[3], m_words[2], m_words[1], m_words[0]});
    chk("model_burst_o", 256'(burst_o), 256'(m_words[m_beats]));
    if (resp_o) resp_cnt++;
  end

  // Waits for the request to reach memory, plays a resp_i pattern (bit 0 first),
  // and leaves time at the negedge where resp_o must be high.
  task automatic burst(input logic exp_wr, input logic [15:0] pat, input int len,
                       input logic [63:0] w0, input logic [63:0] w1,
                       input logic [63:0] w2, input logic [63:0] w3);
    logic [63:0] w [4];
    int k;
    int wait_n;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    k = 0;
    wait_n = 0;
    @(negedge clk);
    while (!(read_o || write_o) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk("request_seen", 256'(read_o || write_o), 256'(1));
    chk("op_select_write", 256'(write_o), 256'(exp_wr));
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #2;
      resp_i  = pat[i];
      burst_i = pat[i] ? w[k] : 64'hBAD0_BAD0_BAD0_0000 + 64'(i);
      @(negedge clk);
      if (exp_wr) chk("write_beat_data", 256'(burst_o), 256'(w[k]));
      if (pat[i]) k++;
    end
    @(posedge clk); #2;
    resp_i = 0;
    burst_i = '0;
    @(negedge clk);
    chk("resp_after_4th_beat", 256'(resp_o), 256'(1));
    chk("read_o_low_with_resp", 256'(read_o), 256'(0));
    chk("write_o_low_with_resp", 256'(write_o), 256'(0));
  endtask

  initial begin
    int rc0;
    rst = 0; read_i = 1; write_i = 0; resp_i = 1;
    address_i = 32'h0000_1234; line_i = '0; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;

    // Reset held with activity on the inputs.
    repeat (2) @(negedge clk);
    chk("rst_read_o", 256'(read_o), 256'(0));
    chk("rst_write_o", 256'(write_o), 256'(0));
    chk("rst_resp_o", 256'(resp_o), 256'(0));
    chk("rst_address_o", 256'(address_o), 256'(0));
    chk("rst_line_o", line_o, 256'(0));
    chk("rst_burst_o", 256'(burst_o), 256'(0));

    @(posedge clk); #2;
    rst = 1; resp_i = 0;
    @(negedge clk);
    chk("read_o_before_sample", 256'(read_o), 256'(0));
    @(negedge clk);
    chk("read_o_after_sample", 256'(read_o), 256'(1));
    chk("fill_address_aligned", 256'(address_o), 256'(32'h0000_1220));

    // Read fill.
    burst(1'b0, 16'h000F, 4, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
    chk("fill_line", line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    @(posedge clk); #2; read_i = 0;
    @(negedge clk);
    chk("fill_resp_single", 256'(resp_o), 256'(0));

    // Stalled writeback, resp_i = 1,0,0,1,1,0,1.
    @(posedge clk); #2;
    address_i = 32'h0000_ABCF;
    line_i = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
              64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    write_i = 1;
    burst(1'b1, 16'h0059, 7, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
          64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D);
    chk("wb_address", 256'(address_o), 256'(32'h0000_ABC0));
    chk("wb_keeps_fill_out_of_line", line_o, line_i);
    @(posedge clk); #2; write_i = 0;
    @(negedge clk);
    chk("wb_resp_single", 256'(resp_o), 256'(0));

    // Simultaneous read and write: write first, then the held read.
    @(posedge clk); #2;
    rc0 = resp_cnt;
    address_i = 32'h8000_0040;
    line_i = {64'h4, 64'h3, 64'h2, 64'h1};
    read_i = 1; write_i = 1;
    burst(1'b1, 16'h000F, 4, 64'h1, 64'h2, 64'h3, 64'h4);
    @(posedge clk); #2; write_i = 0;
    burst(1'b0, 16'h001D, 5, 64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002,
          64'h5555_0000_0000_0003, 64'h5555_0000_0000_0004);
    chk("both_read_line", line_o, {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
                                   64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001});
    @(posedge clk); #2; read_i = 0;
    @(negedge clk);
    chk("both_two_resp_pulses", 256'(resp_cnt - rc0), 256'(2));

    // Reset after two read beats.
    @(posedge clk); #2;
    address_i = 32'h0000_2000; read_i = 1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_read_started", 256'(read_o), 256'(1));
    @(posedge clk); #2; resp_i = 1; burst_i = 64'h7777_7777_7777_7777;
    @(posedge clk); #2; burst_i = 64'h8888_8888_8888_8888;
    @(posedge clk); #2; rst = 0; resp_i = 0;
    #1;
    chk("abort_read_o_drop", 256'(read_o), 256'(0));
    chk("abort_line_cleared", line_o, 256'(0));
    @(posedge clk); #2; rst = 1;
    burst(1'b0, 16'h000F, 4, 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
          64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404);
    chk("post_abort_line", line_o, {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                    64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});
    @(posedge clk); #2; read_i = 0;

    // Back-to-back reads with spurious beats in IDLE.
    @(posedge clk); #2;
    address_i = 32'h0000_3000; read_i = 1;
    burst(1'b0, 16'h000F, 4, 64'hA1, 64'hA2, 64'hA3, 64'hA4);
    @(posedge clk); #2; read_i = 0; resp_i = 1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) begin @(posedge clk); #2; end
    resp_i = 0; address_i = 32'h0000_3020; read_i = 1;
    burst(1'b0, 16'h000F, 4, 64'hB1, 64'hB2, 64'hB3, 64'hB4);
    chk("b2b_second_line", line_o, {64'hB4, 64'hB3, 64'hB2, 64'hB1});
    chk("b2b_second_address", 256'(address_o), 256'(32'h0000_3020));
    @(posedge clk); #2; read_i = 0;
    repeat (2) @(negedge clk);
    chk("b2b_idle_after", 256'(read_o), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
